// File: rtl/abc130_ro_pkg.sv
// Shared readout definitions for LocalL0ID_tri users, the readout sequencer and the packet builder.
package abc130_ro_pkg;

    localparam int RO_ADDR_WIDTH = 8;
    localparam logic [RO_ADDR_WIDTH-1:0] L0ID_RESET_VAL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_ADVANCE,
        ST_APPLY
    } ro_state_t;

endpackage

// File: rtl/l0id_readout_seq_if.sv
// Signal bundle between the readout sequencer and its neighbours
// (command decoder, L0ID hold register, packet builder).
interface l0id_readout_seq_if #(
    parameter int PEND_WIDTH = 4
);
    import abc130_ro_pkg::*;

    logic                     L0;
    logic                     L0IDResetCmd;
    logic                     L0IDPresetCmd;
    logic [RO_ADDR_WIDTH-1:0] PreL0IDIn;
    logic [RO_ADDR_WIDTH-1:0] L0ID_Local;
    logic                     ReadoutDone;
    logic                     ReadoutStart;
    logic [RO_ADDR_WIDTH-1:0] ReadoutL0ID;
    logic                     ROReadStrob;
    logic                     L0IDReset;
    logic                     L0IDPreset;
    logic [RO_ADDR_WIDTH-1:0] PreL0ID;
    logic [PEND_WIDTH-1:0]    PendingCount;
    logic                     Overflow;
    logic                     ReadoutTimeout;

    modport master (
        output L0, L0IDResetCmd, L0IDPresetCmd, PreL0IDIn, L0ID_Local, ReadoutDone,
        input  ReadoutStart, ReadoutL0ID, ROReadStrob, L0IDReset, L0IDPreset, PreL0ID,
               PendingCount, Overflow, ReadoutTimeout
    );

    modport slave (
        input  L0, L0IDResetCmd, L0IDPresetCmd, PreL0IDIn, L0ID_Local, ReadoutDone,
        output ReadoutStart, ReadoutL0ID, ROReadStrob, L0IDReset, L0IDPreset, PreL0ID,
               PendingCount, Overflow, ReadoutTimeout
    );

endinterface

// File: rtl/ro_wait_timer.sv
// Loadable down-counter with terminal flag; stops at zero rather than wrapping.
module ro_wait_timer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/l0id_readout_seq.sv
// Readout sequencer owning the local L0ID hold register: one readout per pending L0,
// register advance after each readout, and timed L0ID reset/preset loads.
//
//   state     | meaning
//   IDLE      | apply a held command, else start a readout if any are pending
//   START     | ReadoutStart pulse; capture L0ID_Local; consume one pending readout
//   WAIT_DONE | wait for ReadoutDone or the wait timer to expire
//   ADVANCE   | ROReadStrob pulse to increment the hold register
//   APPLY     | L0IDReset (and L0IDPreset) pulse; clear pending count and overflow
module l0id_readout_seq
    import abc130_ro_pkg::*;
#(
    parameter int MAX_PENDING = 8,
    parameter int PEND_WIDTH  = 4,
    parameter int TIMEOUT     = 255
) (
    input logic               CLK,
    input logic               Reset,
    l0id_readout_seq_if.slave bus
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]      TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = PEND_WIDTH'(MAX_PENDING);
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

    ro_state_t                state;
    logic                     rd_start;
    logic                     ro_strob;
    logic                     l0id_rst;
    logic                     l0id_pre;
    logic                     overflow;
    logic                     rd_timeout;
    logic                     cmd_held;
    logic                     cmd_preset;
    logic [RO_ADDR_WIDTH-1:0] rd_l0id;
    logic [RO_ADDR_WIDTH-1:0] pre_l0id;
    logic [PEND_WIDTH-1:0]    pend_cnt;
    logic                     tmr_load;
    logic                     tmr_en;
    logic                     tmr_done;

    // Loading TIMEOUT-1 on the START edge makes the terminal flag appear in the TIMEOUT-th wait cycle.
    assign tmr_load = (state == ST_START);
    assign tmr_en   = (state == ST_WAIT_DONE);

    ro_wait_timer #(
        .WIDTH(TMR_W)
    ) u_wait_timer (
        .CLK      (CLK),
        .Reset    (Reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (TMR_LOAD),
        .terminal (tmr_done)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            rd_start   <= 1'b0;
            ro_strob   <= 1'b0;
            l0id_rst   <= 1'b0;
            l0id_pre   <= 1'b0;
            overflow   <= 1'b0;
            rd_timeout <= 1'b0;
            cmd_held   <= 1'b0;
            cmd_preset <= 1'b0;
            rd_l0id    <= L0ID_RESET_VAL;
            pre_l0id   <= L0ID_RESET_VAL;
            pend_cnt   <= '0;
        end else begin
            rd_start <= 1'b0;
            ro_strob <= 1'b0;
            l0id_rst <= 1'b0;
            l0id_pre <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_held) begin
                        state    <= ST_APPLY;
                        l0id_rst <= 1'b1;
                        l0id_pre <= cmd_preset;
                    end else if (pend_cnt != '0) begin
                        state    <= ST_START;
                        rd_start <= 1'b1;
                    end
                end
                ST_START: begin
                    rd_l0id <= bus.L0ID_Local;
                    state   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (bus.ReadoutDone) begin
                        state    <= ST_ADVANCE;
                        ro_strob <= 1'b1;
                    end else if (tmr_done) begin
                        state      <= ST_ADVANCE;
                        ro_strob   <= 1'b1;
                        rd_timeout <= 1'b1;
                    end
                end
                ST_ADVANCE: state <= ST_IDLE;
                ST_APPLY:   state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase

            // The held command is consumed on the edge into APPLY so a command arriving
            // during APPLY itself is kept and applied on the next pass through IDLE.
            if (bus.L0IDPresetCmd) begin
                cmd_held   <= 1'b1;
                cmd_preset <= 1'b1;
                pre_l0id   <= bus.PreL0IDIn;
            end else if (bus.L0IDResetCmd) begin
                cmd_held   <= 1'b1;
                cmd_preset <= 1'b0;
            end else if ((state == ST_IDLE) && cmd_held) begin
                cmd_held <= 1'b0;
            end

            if (state == ST_APPLY) begin
                pend_cnt <= bus.L0 ? PEND_ONE : '0;
                overflow <= 1'b0;
            end else if (state == ST_START) begin
                if (!bus.L0) begin
                    pend_cnt <= pend_cnt - PEND_ONE;
                end
            end else if (bus.L0) begin
                if (pend_cnt == PEND_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt + PEND_ONE;
                end
            end
        end
    end

    assign bus.ReadoutStart   = rd_start;
    assign bus.ReadoutL0ID    = rd_l0id;
    assign bus.ROReadStrob    = ro_strob;
    assign bus.L0IDReset      = l0id_rst;
    assign bus.L0IDPreset     = l0id_pre;
    assign bus.PreL0ID        = pre_l0id;
    assign bus.PendingCount   = pend_cnt;
    assign bus.Overflow       = overflow;
    assign bus.ReadoutTimeout = rd_timeout;

endmodule

// File: tb/tb_l0id_readout_seq.sv
// Directed self-checking bench for l0id_readout_seq with a behavioural L0ID hold register.
module tb_l0id_readout_seq;
    import abc130_ro_pkg::*;

    logic CLK = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad = 0;
    logic [RO_ADDR_WIDTH-1:0] l0id_model;

    l0id_readout_seq_if #(.PEND_WIDTH(4)) bus ();

    l0id_readout_seq #(
        .MAX_PENDING(8),
        .PEND_WIDTH (4),
        .TIMEOUT    (255)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Hold register: loads on L0IDReset, increments on ROReadStrob.
    assign bus.L0ID_Local = l0id_model;
    always @(posedge CLK or posedge Reset) begin
        if (Reset) l0id_model <= 8'hFF;
        else if (bus.L0IDReset) l0id_model <= bus.L0IDPreset ? bus.PreL0ID : 8'hFF;
        else if (bus.ROReadStrob) l0id_model <= l0id_model + 8'd1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.L0 = 1'b0; bus.L0IDResetCmd = 1'b0; bus.L0IDPresetCmd = 1'b0;
        bus.PreL0IDIn = 8'h00; bus.ReadoutDone = 1'b0;
        tick(); tick();
        total++; if (bus.ReadoutStart !== 1'b0) begin bad++; $display("FAIL reset_start: got %b exp 0", bus.ReadoutStart); end
        total++; if (bus.ReadoutL0ID !== 8'hFF) begin bad++; $display("FAIL reset_rdid: got %h exp ff", bus.ReadoutL0ID); end
        total++; if (bus.PreL0ID !== 8'hFF) begin bad++; $display("FAIL reset_preid: got %h exp ff", bus.PreL0ID); end
        total++; if (bus.PendingCount !== 4'd0) begin bad++; $display("FAIL reset_pend: got %0d exp 0", bus.PendingCount); end
        total++; if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b exp 0", bus.Overflow); end
        total++; if (bus.ReadoutTimeout !== 1'b0) begin bad++; $display("FAIL reset_tmo: got %b exp 0", bus.ReadoutTimeout); end
        total++; if (bus.ROReadStrob !== 1'b0) begin bad++; $display("FAIL reset_strob: got %b exp 0", bus.ROReadStrob); end
        total++; if (bus.L0IDReset !== 1'b0 || bus.L0IDPreset !== 1'b0) begin bad++; $display("FAIL reset_l0idrst: got %b%b exp 00", bus.L0IDReset, bus.L0IDPreset); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single_event();
        int n;
        bus.L0IDResetCmd = 1'b1; tick(); bus.L0IDResetCmd = 1'b0;
        tick();
        total++; if (bus.L0IDReset !== 1'b1 || bus.L0IDPreset !== 1'b0) begin bad++; $display("FAIL single_cmd_rst: got %b%b exp 10", bus.L0IDReset, bus.L0IDPreset); end
        tick();
        total++; if (bus.L0IDReset !== 1'b0) begin bad++; $display("FAIL single_cmd_pulse: got %b exp 0", bus.L0IDReset); end
        bus.L0 = 1'b1; tick(); bus.L0 = 1'b0;
        total++; if (bus.PendingCount !== 4'd1) begin bad++; $display("FAIL single_pend1: got %0d exp 1", bus.PendingCount); end
        total++; if (bus.ReadoutStart !== 1'b0) begin bad++; $display("FAIL single_early_start: got %b exp 0", bus.ReadoutStart); end
        tick();
        total++; if (bus.ReadoutStart !== 1'b1) begin bad++; $display("FAIL single_start: got %b exp 1", bus.ReadoutStart); end
        tick();
        total++; if (bus.ReadoutStart !== 1'b0) begin bad++; $display("FAIL single_start_len: got %b exp 0", bus.ReadoutStart); end
        total++; if (bus.ReadoutL0ID !== 8'hFF) begin bad++; $display("FAIL single_rdid: got %h exp ff", bus.ReadoutL0ID); end
        total++; if (bus.PendingCount !== 4'd0) begin bad++; $display("FAIL single_pend0: got %0d exp 0", bus.PendingCount); end
        tick(); tick();
        total++; if (bus.ROReadStrob !== 1'b0) begin bad++; $display("FAIL single_early_strob: got %b exp 0", bus.ROReadStrob); end
        bus.ReadoutDone = 1'b1; tick(); bus.ReadoutDone = 1'b0;
        total++; if (bus.ROReadStrob !== 1'b1) begin bad++; $display("FAIL single_strob: got %b exp 1", bus.ROReadStrob); end
        n = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (bus.ROReadStrob === 1'b1) n++; end
        total++; if (n !== 0) begin bad++; $display("FAIL single_extra_strob: got %0d exp 0", n); end
        total++; if (bus.PendingCount !== 4'd0) begin bad++; $display("FAIL single_pend_end: got %0d exp 0", bus.PendingCount); end
    endtask

    task automatic test_burst();
        int n;
        for (int i = 0; i < 10; i++) begin bus.L0 = 1'b1; tick(); end
        bus.L0 = 1'b0;
        total++; if (bus.PendingCount !== 4'd8) begin bad++; $display("FAIL burst_sat: got %0d exp 8", bus.PendingCount); end
        total++; if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL burst_ovf: got %b exp 1", bus.Overflow); end
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                n = 0;
                while (bus.ReadoutStart !== 1'b1 && n < 10) begin tick(); n++; end
                total++; if (bus.ReadoutStart !== 1'b1) begin bad++; $display("FAIL burst_start_%0d: got %b exp 1", i, bus.ReadoutStart); end
                if (i == 1) begin
                    total++; if (n !== 2) begin bad++; $display("FAIL burst_gap: got %0d exp 2", n); end
                end
                tick();
            end
            total++; if (bus.ReadoutL0ID !== 8'(i)) begin bad++; $display("FAIL burst_rdid_%0d: got %h exp %h", i, bus.ReadoutL0ID, 8'(i)); end
            bus.ReadoutDone = 1'b1; tick(); bus.ReadoutDone = 1'b0;
            total++; if (bus.ROReadStrob !== 1'b1) begin bad++; $display("FAIL burst_strob_%0d: got %b exp 1", i, bus.ROReadStrob); end
        end
        tick(); tick(); tick();
        total++; if (bus.PendingCount !== 4'd0) begin bad++; $display("FAIL burst_pend_end: got %0d exp 0", bus.PendingCount); end
        total++; if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL burst_ovf_sticky: got %b exp 1", bus.Overflow); end
    endtask

    task automatic test_midreadout_preset();
        for (int i = 0; i < 3; i++) begin bus.L0 = 1'b1; tick(); end
        bus.L0 = 1'b0;
        total++; if (bus.PendingCount !== 4'd2) begin bad++; $display("FAIL pre_pend2: got %0d exp 2", bus.PendingCount); end
        total++; if (bus.ReadoutL0ID !== 8'h09) begin bad++; $display("FAIL pre_rdid: got %h exp 09", bus.ReadoutL0ID); end
        bus.PreL0IDIn = 8'h3C; bus.L0IDPresetCmd = 1'b1; tick();
        bus.L0IDPresetCmd = 1'b0; bus.PreL0IDIn = 8'h00;
        total++; if (bus.PreL0ID !== 8'h3C) begin bad++; $display("FAIL pre_latch: got %h exp 3c", bus.PreL0ID); end
        total++; if (bus.L0IDReset !== 1'b0) begin bad++; $display("FAIL pre_early_apply: got %b exp 0", bus.L0IDReset); end
        tick();
        total++; if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL pre_ovf_before: got %b exp 1", bus.Overflow); end
        bus.ReadoutDone = 1'b1; tick(); bus.ReadoutDone = 1'b0;
        total++; if (bus.ROReadStrob !== 1'b1) begin bad++; $display("FAIL pre_strob: got %b exp 1", bus.ROReadStrob); end
        tick();
        total++; if (bus.L0IDReset !== 1'b0 || bus.ReadoutStart !== 1'b0) begin bad++; $display("FAIL pre_idle: got rst=%b start=%b exp 0 0", bus.L0IDReset, bus.ReadoutStart); end
        tick();
        total++; if (bus.L0IDReset !== 1'b1 || bus.L0IDPreset !== 1'b1) begin bad++; $display("FAIL pre_apply: got %b%b exp 11", bus.L0IDReset, bus.L0IDPreset); end
        total++; if (bus.PreL0ID !== 8'h3C) begin bad++; $display("FAIL pre_value: got %h exp 3c", bus.PreL0ID); end
        total++; if (bus.ReadoutStart !== 1'b0) begin bad++; $display("FAIL pre_start_apply: got %b exp 0", bus.ReadoutStart); end
        tick();
        total++; if (bus.PendingCount !== 4'd0) begin bad++; $display("FAIL pre_pend_clr: got %0d exp 0", bus.PendingCount); end
        total++; if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL pre_ovf_clr: got %b exp 0", bus.Overflow); end
        tick(); tick();
        total++; if (bus.ReadoutStart !== 1'b0) begin bad++; $display("FAIL pre_no_start: got %b exp 0", bus.ReadoutStart); end
    endtask

    task automatic test_timeout();
        int early;
        bus.L0 = 1'b1; tick(); bus.L0 = 1'b0;
        tick(); tick();
        total++; if (bus.ReadoutL0ID !== 8'h3C) begin bad++; $display("FAIL tmo_rdid: got %h exp 3c", bus.ReadoutL0ID); end
        early = 0;
        for (int k = 0; k < 254; k++) begin
            tick();
            if (bus.ROReadStrob === 1'b1 || bus.ReadoutTimeout === 1'b1) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL tmo_early: got %0d exp 0", early); end
        tick();
        total++; if (bus.ReadoutTimeout !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b exp 1", bus.ReadoutTimeout); end
        total++; if (bus.ROReadStrob !== 1'b1) begin bad++; $display("FAIL tmo_strob: got %b exp 1", bus.ROReadStrob); end
        tick();
        total++; if (bus.ROReadStrob !== 1'b0) begin bad++; $display("FAIL tmo_strob_len: got %b exp 0", bus.ROReadStrob); end
        bus.ReadoutDone = 1'b1; tick(); bus.ReadoutDone = 1'b0;
        total++; if (bus.ROReadStrob !== 1'b0) begin bad++; $display("FAIL idle_done_ignored: got %b exp 0", bus.ROReadStrob); end
        tick();
        total++; if (bus.ReadoutTimeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b exp 1", bus.ReadoutTimeout); end
    endtask

    task automatic test_simultaneous();
        bus.L0 = 1'b1; tick(); bus.L0 = 1'b0;
        tick();
        total++; if (bus.ReadoutStart !== 1'b1 || bus.PendingCount !== 4'd1) begin bad++; $display("FAIL sim_start: got start=%b pend=%0d exp 1 1", bus.ReadoutStart, bus.PendingCount); end
        bus.L0 = 1'b1; tick(); bus.L0 = 1'b0;
        total++; if (bus.PendingCount !== 4'd1) begin bad++; $display("FAIL sim_l0_in_start: got %0d exp 1", bus.PendingCount); end
        total++; if (bus.ReadoutL0ID !== 8'h3D) begin bad++; $display("FAIL sim_rdid: got %h exp 3d", bus.ReadoutL0ID); end
        bus.L0IDResetCmd = 1'b1; bus.L0IDPresetCmd = 1'b1; bus.PreL0IDIn = 8'hA5; tick();
        bus.L0IDResetCmd = 1'b0; bus.L0IDPresetCmd = 1'b0; bus.PreL0IDIn = 8'h00;
        total++; if (bus.PreL0ID !== 8'hA5) begin bad++; $display("FAIL sim_pre_latch: got %h exp a5", bus.PreL0ID); end
        bus.ReadoutDone = 1'b1; tick(); bus.ReadoutDone = 1'b0;
        total++; if (bus.ROReadStrob !== 1'b1) begin bad++; $display("FAIL sim_strob: got %b exp 1", bus.ROReadStrob); end
        tick(); tick();
        total++; if (bus.L0IDReset !== 1'b1 || bus.L0IDPreset !== 1'b1) begin bad++; $display("FAIL sim_preset_wins: got %b%b exp 11", bus.L0IDReset, bus.L0IDPreset); end
        total++; if (bus.ReadoutStart !== 1'b0) begin bad++; $display("FAIL sim_cmd_priority: got %b exp 0", bus.ReadoutStart); end
        bus.L0 = 1'b1; tick(); bus.L0 = 1'b0;
        total++; if (bus.PendingCount !== 4'd1) begin bad++; $display("FAIL sim_l0_in_apply: got %0d exp 1", bus.PendingCount); end
        tick();
        total++; if (bus.ReadoutStart !== 1'b1) begin bad++; $display("FAIL sim_start2: got %b exp 1", bus.ReadoutStart); end
        tick();
        total++; if (bus.ReadoutL0ID !== 8'hA5) begin bad++; $display("FAIL sim_rdid2: got %h exp a5", bus.ReadoutL0ID); end
        bus.ReadoutDone = 1'b1; tick(); bus.ReadoutDone = 1'b0;
        total++; if (bus.ROReadStrob !== 1'b1) begin bad++; $display("FAIL sim_strob2: got %b exp 1", bus.ROReadStrob); end
        tick(); tick();
    endtask

    task automatic test_async_reset();
        int n;
        for (int i = 0; i < 3; i++) begin bus.L0 = 1'b1; tick(); end
        bus.L0 = 1'b0;
        tick();
        total++; if (bus.ReadoutL0ID !== 8'hA6 || bus.PendingCount !== 4'd2) begin bad++; $display("FAIL arst_pre: got id=%h pend=%0d exp a6 2", bus.ReadoutL0ID, bus.PendingCount); end
        Reset = 1'b1; #1;
        total++; if (bus.ReadoutL0ID !== 8'hFF) begin bad++; $display("FAIL arst_rdid: got %h exp ff", bus.ReadoutL0ID); end
        total++; if (bus.PreL0ID !== 8'hFF) begin bad++; $display("FAIL arst_preid: got %h exp ff", bus.PreL0ID); end
        total++; if (bus.PendingCount !== 4'd0) begin bad++; $display("FAIL arst_pend: got %0d exp 0", bus.PendingCount); end
        total++; if (bus.ReadoutTimeout !== 1'b0) begin bad++; $display("FAIL arst_tmo: got %b exp 0", bus.ReadoutTimeout); end
        total++; if (bus.ROReadStrob !== 1'b0 || bus.ReadoutStart !== 1'b0) begin bad++; $display("FAIL arst_pulses: got %b%b exp 00", bus.ROReadStrob, bus.ReadoutStart); end
        bus.ReadoutDone = 1'b1; tick(); bus.ReadoutDone = 1'b0;
        Reset = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.ROReadStrob === 1'b1 || bus.ReadoutStart === 1'b1) n++;
        end
        total++; if (n !== 0) begin bad++; $display("FAIL arst_no_strob: got %0d exp 0", n); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_burst();
        test_midreadout_preset();
        test_timeout();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l0id_readout_seq.md
# l0id_readout_seq

Readout sequencer that owns the local L0ID hold register (`LocalL0ID_tri`):
- counts accepted L0 triggers as pending readouts;
- for each pending readout, hands the current L0ID to the packet builder and waits for completion;
- after completion, pulses `ROReadStrob` to advance the register;
- turns L0ID reset/preset commands into correctly timed `L0IDReset`/`L0IDPreset` pulses with a latched preset value.

It sits between the command decoder, the L0ID register and the readout packet builder.

## Interface
- `MAX_PENDING`, default 8: pending-readout counter saturation value.
- `PEND_WIDTH`, default 4: width of the pending count; must hold `MAX_PENDING`.
- `TIMEOUT`, default 255: cycles allowed in WAIT_DONE before a forced advance.
- `CLK`  in  1  BC clock. One clock only, all logic on the rising edge.
- `Reset`  in  1  Asynchronous, active-high reset.
- `L0`  in  1  One-cycle accepted-trigger pulse.
- `L0IDResetCmd`  in  1  One-cycle command: reset L0ID to `8'hFF`.
- `L0IDPresetCmd`  in  1  One-cycle command: preset L0ID to `PreL0IDIn`.
- `PreL0IDIn`  in  `RO_ADDR_WIDTH`  Preset value, sampled with `L0IDPresetCmd`.
- `L0ID_Local`  in  `RO_ADDR_WIDTH`  Current L0ID from the hold register.
- `ReadoutDone`  in  1  One-cycle pulse from the packet builder: event finished.
- `ReadoutStart`  out  1  One-cycle pulse: start event readout.
- `ReadoutL0ID`  out  `RO_ADDR_WIDTH`  L0ID of the event being read; held stable until the next start.
- `ROReadStrob`  out  1  One-cycle pulse to the hold register (increment).
- `L0IDReset`  out  1  One-cycle pulse to the hold register.
- `L0IDPreset`  out  1  Qualifies `L0IDReset` as a preset load.
- `PreL0ID`  out  `RO_ADDR_WIDTH`  Latched preset value driven to the hold register.
- `PendingCount`  out  `PEND_WIDTH`  Readouts not yet advanced; excludes the one in progress.
- `Overflow`  out  1  Sticky: an L0 arrived while `PendingCount == MAX_PENDING`.
- `ReadoutTimeout`  out  1  Sticky: a WAIT_DONE timeout occurred.

All outputs reset to 0, except `ReadoutL0ID` and `PreL0ID`, which reset to `8'hFF`.

## Operation
- **States:** IDLE, START, WAIT_DONE, ADVANCE, APPLY.
- **IDLE:**
  - If a command is held, go to APPLY. Commands take priority over readout.
  - Otherwise, if `PendingCount > 0`, go to START.
- **START:**
  - Capture `L0ID_Local` into `ReadoutL0ID`.
  - Pulse `ReadoutStart`.
  - Decrement `PendingCount`.
  - Go to WAIT_DONE.
- **WAIT_DONE:**
  - Go to ADVANCE on `ReadoutDone`.
  - Also go to ADVANCE when the wait counter reaches `TIMEOUT`; in that case set `ReadoutTimeout`.
  - The wait counter clears on entry.
- **ADVANCE:**
  - Pulse `ROReadStrob`.
  - Go to IDLE. `L0ID_Local` carries the incremented value from the following cycle.
- **APPLY:**
  - Pulse `L0IDReset`. For a preset, also drive `L0IDPreset` high in the same cycle.
  - Clear `PendingCount`, `Overflow` and the held command.
  - Go to IDLE.
- **Command holding:**
  - A command is captured in any state into a single-entry holding register, so it is never lost mid-readout.
  - The newest command overwrites an older unapplied one.
  - On `L0IDPresetCmd`, `PreL0ID` latches `PreL0IDIn`.
- **Pending counter:**
  - Increments on `L0`.
  - An `L0` in the START cycle nets to zero change.
  - Saturates at `MAX_PENDING`; an `L0` while full sets `Overflow`, and the count stays unchanged.
  - In APPLY, an `L0` in the same cycle leaves `PendingCount = 1` after the clear.
- **Simultaneous commands:** when `L0IDResetCmd` and `L0IDPresetCmd` arrive together, preset wins.
- **Asynchronous reset:**
  - Returns the FSM to IDLE at any point and clears all counters and flags.
  - A readout in progress is abandoned without an `ROReadStrob`.
- `ReadoutDone` outside WAIT_DONE is ignored.

## Timing
- First `L0` in an empty, idle block:
  - `L0` sampled at edge 0, so `PendingCount = 1` after edge 0.
  - START entered after edge 1.
  - `ReadoutStart` high during the cycle after edge 1.
  - `ReadoutL0ID` valid from edge 2.
- `ReadoutDone` sampled at edge N:
  - `ROReadStrob` high during the cycle after edge N.
  - Next START no earlier than 2 cycles after `ROReadStrob`.
- Minimum throughput: one event per 4 cycles plus readout time.
- A command in IDLE reaches `L0IDReset` 2 cycles after the command.
- A command held during readout is applied in the 2nd cycle after ADVANCE, before any further START.
- Timeout fires on the `TIMEOUT`-th cycle in WAIT_DONE.

## Structure
- Shared package `abc130_ro_pkg`:
  - `RO_ADDR_WIDTH` (8) and the L0ID reset value `8'hFF`;
  - the FSM state enum.
- The package is used by `LocalL0ID_tri` users and the packet builder.
- Sub-module `ro_wait_timer`: loadable down-counter with terminal flag, used for the WAIT_DONE timeout.
- FSM, pending counter and command holding stay in the top level.

## Test plan
- **Single event:** Reset, then `L0IDResetCmd`, then one `L0` with `L0ID_Local` at `FF` -> `ReadoutStart` with `ReadoutL0ID = FF`. After `ReadoutDone`, exactly one `ROReadStrob`; `PendingCount` returns to 0.
- **Burst:** 10 `L0`s back-to-back with `MAX_PENDING = 8` -> `PendingCount` saturates at 8 and `Overflow = 1`. Strobes occur in order as `ReadoutDone` arrives.
- **Mid-readout preset:** `L0IDPresetCmd` with `PreL0IDIn = 8'h3C` during WAIT_DONE, 2 events still pending -> current event gets `ROReadStrob`. Then `L0IDReset` with `L0IDPreset` high and `PreL0ID = 3C`; `PendingCount` becomes 0; `Overflow` clears.
- **Timeout:** No `ReadoutDone` -> `ReadoutTimeout = 1` after 255 cycles in WAIT_DONE, followed by one `ROReadStrob`.
- **Simultaneous events:** `L0` in the START cycle -> `PendingCount` unchanged. Reset and preset commands together -> preset applied.
- **Asynchronous reset mid-readout:** `Reset` asserted during WAIT_DONE -> all outputs immediately at reset values; no `ROReadStrob`.
